// File: rtl/gen_fifo_burst_rdr.sv
// Burst read controller for zero-delay push/pop FIFOs.
// It waits for a full burst or a timed-out partial burst, then drains it onto a valid/ready stream.
module gen_fifo_burst_rdr #(
   parameter  int DEPTH = 16,
   parameter  int DAT_W = 4,
   parameter  int TMO_W = 8,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_en,
   input  logic [CNT_W-1:0] cfg_burst_len,
   input  logic [TMO_W-1:0] cfg_tmo,
   input  logic [DAT_W-1:0] fifo_dat,
   input  logic             fifo_empty,
   input  logic [CNT_W-1:0] fifo_count,
   output logic             fifo_pop,
   output logic [DAT_W-1:0] out_dat,
   output logic             out_vld,
   output logic             out_last,
   input  logic             out_rdy,
   output logic             sts_busy,
   output logic             sts_flush,
   output logic [15:0]      sts_burst_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   localparam logic [TMO_W-1:0] TMO_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [15:0]      burst_cnt_q, burst_cnt_d;
   logic             flush_q, flush_d;

   logic [CNT_W-1:0] len;
   logic             full_hit;
   logic             tmo_hit;

   // A zero burst length still moves one word per burst.
   assign len      = (cfg_burst_len == '0) ? CNT_W'(1) : cfg_burst_len;
   assign full_hit = (fifo_count >= len);
   assign tmo_hit  = (cfg_tmo != '0) && (fifo_count != '0) &&
                     (tmo_cnt_q == cfg_tmo - TMO_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: every flop here is assigned with <= so all of them sample the pre-edge values.
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         tmo_cnt_q   <= '0;
         burst_cnt_q <= '0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         tmo_cnt_q   <= tmo_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         flush_q     <= flush_d;
      end
   end

   // Next-state and registered-datapath logic
   always_comb begin
      // NOTE: defaults first so no path leaves a *_d unassigned and infers a latch.
      state_d     = state_q;
      rem_d       = rem_q;
      tmo_cnt_d   = tmo_cnt_q;
      burst_cnt_d = burst_cnt_q;
      flush_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_en) state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (!cfg_en) begin
               state_d   = ST_IDLE;
               tmo_cnt_d = '0;
            end else if (full_hit) begin
               state_d   = ST_BURST;
               rem_d     = len;
               tmo_cnt_d = '0;
            end else if (tmo_hit) begin
               // A short burst drains exactly what is stored now.
               state_d   = ST_BURST;
               rem_d     = fifo_count;
               flush_d   = 1'b1;
               tmo_cnt_d = '0;
            end else if (fifo_count != '0) begin
               if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end else begin
               tmo_cnt_d = '0;
            end
         end

         ST_BURST: begin
            if (fifo_pop) begin
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  burst_cnt_d = burst_cnt_q + 16'd1;
                  state_d     = cfg_en ? ST_WAIT : ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      sts_busy = 1'b0;
      out_vld  = 1'b0;
      out_last = 1'b0;
      if (state_q == ST_BURST) begin
         sts_busy = 1'b1;
         out_vld  = ~fifo_empty;
         out_last = (rem_q == CNT_W'(1));
      end
   end

   assign fifo_pop      = out_vld & out_rdy;
   assign out_dat       = fifo_dat;
   assign sts_flush     = flush_q;
   assign sts_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_gen_fifo_burst_rdr.sv
// Self-checking bench for gen_fifo_burst_rdr: a queue-based FIFO, a behavioural burst model,
// directed scenarios with literal expectations and a randomized soak.
module tb_gen_fifo_burst_rdr;

   localparam int DEPTH = 16;
   localparam int DAT_W = 4;
   localparam int TMO_W = 8;
   localparam int CNT_W = 5;
   localparam int TMO_SAT = (1 << TMO_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_en;
   logic [CNT_W-1:0] cfg_burst_len;
   logic [TMO_W-1:0] cfg_tmo;
   logic [DAT_W-1:0] fifo_dat;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_pop;
   logic [DAT_W-1:0] out_dat;
   logic             out_vld;
   logic             out_last;
   logic             out_rdy;
   logic             sts_busy;
   logic             sts_flush;
   logic [15:0]      sts_burst_cnt;

   always #5 clk = ~clk;

   gen_fifo_burst_rdr #(.DEPTH(DEPTH), .DAT_W(DAT_W), .TMO_W(TMO_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_en       (cfg_en),
      .cfg_burst_len(cfg_burst_len),
      .cfg_tmo      (cfg_tmo),
      .fifo_dat     (fifo_dat),
      .fifo_empty   (fifo_empty),
      .fifo_count   (fifo_count),
      .fifo_pop     (fifo_pop),
      .out_dat      (out_dat),
      .out_vld      (out_vld),
      .out_last     (out_last),
      .out_rdy      (out_rdy),
      .sts_busy     (sts_busy),
      .sts_flush    (sts_flush),
      .sts_burst_cnt(sts_burst_cnt)
   );

   // FIFO contents, words to push at the next edge, and words seen on the stream {last, dat}
   logic [DAT_W-1:0] fq[$];
   logic [DAT_W-1:0] push_now[$];
   logic [DAT_W:0]   rx[$];
   logic [DAT_W-1:0] exp_w[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;
   int n_flush  = 0;
   logic s_pop  = 1'b0;

   // Behavioural model: words left in the current burst (0 = not bursting), armed = enabled and waiting
   bit m_valid  = 1'b0;
   bit m_armed  = 1'b0;
   bit m_flush  = 1'b0;
   int m_left   = 0;
   int m_pend   = 0;
   int m_bursts = 0;

   int               c_occ;
   logic [DAT_W-1:0] c_dat;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      fifo_count = CNT_W'(fq.size());
      fifo_empty = (fq.size() == 0);
      fifo_dat   = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic model_step();
      int occ = fq.size();
      int len = (cfg_burst_len == '0) ? 1 : int'(cfg_burst_len);
      if (!rst_n) begin
         m_valid = 1'b1; m_armed = 1'b0; m_flush = 1'b0;
         m_left = 0; m_pend = 0; m_bursts = 0;
      end else if (m_valid) begin
         m_flush = 1'b0;
         if (m_left > 0) begin
            if (occ > 0 && out_rdy) begin
               m_left--;
               if (m_left == 0) begin
                  m_bursts = (m_bursts + 1) % 65536;
                  m_armed  = cfg_en;
               end
            end
         end else if (!m_armed) begin
            m_armed = cfg_en;
         end else if (!cfg_en) begin
            m_armed = 1'b0;
            m_pend  = 0;
         end else if (occ >= len) begin
            m_left = len;
            m_pend = 0;
         end else if (cfg_tmo != 0 && occ != 0 && m_pend == int'(cfg_tmo) - 1) begin
            m_left  = occ;
            m_flush = 1'b1;
            m_pend  = 0;
         end else if (occ != 0) begin
            if (m_pend < TMO_SAT) m_pend++;
         end else begin
            m_pend = 0;
         end
      end
   endtask

   // One clock: the edge commits the model, the FIFO pop seen before the edge, then queued pushes
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      if (s_pop && fq.size() > 0) void'(fq.pop_front());
      while (push_now.size() > 0) begin
         if (fq.size() < DEPTH) fq.push_back(push_now.pop_front());
         else void'(push_now.pop_front());
      end
      drive_fifo();
   endtask

   task automatic wait_busy(input int max, output int cyc);
      cyc = 0;
      while (!sts_busy && cyc < max) begin
         tick();
         cyc++;
      end
      check("wait_busy_bound", int'(sts_busy), 1);
   endtask

   task automatic drain(input int max, output int cyc);
      cyc = 0;
      while (sts_busy && cyc < max) begin
         tick();
         cyc++;
      end
      check("drain_bound", int'(sts_busy), 0);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_words"}, rx.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < rx.size(); i++) begin
         check({tag, "_dat"}, int'(rx[i][DAT_W-1:0]), int'(exp_w[i]));
         check({tag, "_last"}, int'(rx[i][DAT_W]), int'(i == exp_w.size() - 1));
      end
      rx.delete();
   endtask

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      s_pop = fifo_pop;
      if (fifo_pop) n_pops++;
      if (sts_flush) n_flush++;
      if (out_vld && out_rdy) rx.push_back({out_last, out_dat});
      if (m_valid) begin
         c_occ = fq.size();
         c_dat = (c_occ != 0) ? fq[0] : '0;
         check("busy",  int'(sts_busy),  int'(m_left > 0));
         check("vld",   int'(out_vld),   int'(m_left > 0 && c_occ > 0));
         check("last",  int'(out_last),  int'(m_left == 1));
         check("pop",   int'(fifo_pop),  int'(m_left > 0 && c_occ > 0 && out_rdy));
         check("dat",   int'(out_dat),   int'(c_dat));
         check("flush", int'(sts_flush), int'(m_flush));
         check("bcnt",  int'(sts_burst_cnt), m_bursts);
      end
   end

   int cyc;
   int p0;
   int f0;

   initial begin
      rst_n = 1'b0; cfg_en = 1'b0; cfg_burst_len = '0; cfg_tmo = '0; out_rdy = 1'b0;
      drive_fifo();
      tick();
      tick();
      check("rst_busy", int'(sts_busy), 0);
      check("rst_vld",  int'(out_vld), 0);
      check("rst_pop",  int'(fifo_pop), 0);
      check("rst_bcnt", int'(sts_burst_cnt), 0);
      rst_n = 1'b1;
      tick();
      check("idle_hold", int'(sts_busy), 0);

      // Full burst
      cfg_en = 1'b1; cfg_burst_len = 5'd4; cfg_tmo = '0; out_rdy = 1'b1;
      tick();
      rx.delete();
      p0 = n_pops;
      push_now = '{4'hA, 4'hB, 4'hC, 4'hD};
      tick();
      wait_busy(10, cyc);
      check("t1_latency", cyc, 1);
      drain(20, cyc);
      check("t1_burst_cycles", cyc, 4);
      exp_w = '{4'hA, 4'hB, 4'hC, 4'hD};
      check_rx("t1");
      check("t1_bcnt", int'(sts_burst_cnt), 1);
      check("t1_fifo_left", fq.size(), 0);
      check("t1_pops", n_pops - p0, 4);

      // Backpressure with out_rdy alternating
      p0 = n_pops;
      push_now = '{4'h1, 4'h2, 4'h3, 4'h4};
      tick();
      wait_busy(10, cyc);
      cyc = 0;
      while (sts_busy && cyc < 40) begin
         tick();
         cyc++;
         out_rdy = (cyc % 2 == 0);
      end
      out_rdy = 1'b1;
      check("t2_burst_cycles", cyc, 7);
      exp_w = '{4'h1, 4'h2, 4'h3, 4'h4};
      check_rx("t2");
      check("t2_pops", n_pops - p0, 4);
      check("t2_bcnt", int'(sts_burst_cnt), 2);

      // Timeout flush of a partial burst
      cfg_burst_len = 5'd8; cfg_tmo = 8'd5;
      tick();
      f0 = n_flush;
      push_now = '{4'h7, 4'h8, 4'h9};
      tick();
      wait_busy(20, cyc);
      check("t3_tmo_latency", cyc, 5);
      check("t3_flush_first", int'(sts_flush), 1);
      drain(20, cyc);
      check("t3_burst_cycles", cyc, 3);
      exp_w = '{4'h7, 4'h8, 4'h9};
      check_rx("t3");
      check("t3_flush_pulses", n_flush - f0, 1);

      // Full burst wins over a simultaneous timeout
      cfg_burst_len = 5'd2; cfg_tmo = 8'd1;
      tick();
      f0 = n_flush;
      push_now = '{4'h5, 4'h6};
      tick();
      wait_busy(10, cyc);
      check("t4_latency", cyc, 1);
      drain(20, cyc);
      exp_w = '{4'h5, 4'h6};
      check_rx("t4");
      check("t4_no_flush", n_flush - f0, 0);

      // Disable mid-burst: burst completes, then no pops until re-enabled
      cfg_burst_len = 5'd4; cfg_tmo = '0;
      tick();
      push_now = '{4'h1, 4'h2, 4'h3, 4'h4};
      tick();
      wait_busy(10, cyc);
      tick();
      tick();
      cfg_en = 1'b0;
      push_now = '{4'h5, 4'h6, 4'h7, 4'h8};
      tick();
      tick();
      check("t5_idle", int'(sts_busy), 0);
      exp_w = '{4'h1, 4'h2, 4'h3, 4'h4};
      check_rx("t5");
      p0 = n_pops;
      repeat (10) tick();
      check("t5_no_pop", n_pops - p0, 0);
      check("t5_fifo_held", fq.size(), 4);
      cfg_en = 1'b1;
      wait_busy(10, cyc);
      check("t5_reenable_latency", cyc, 2);
      drain(20, cyc);
      exp_w = '{4'h5, 4'h6, 4'h7, 4'h8};
      check_rx("t5b");

      // Reset mid-burst after one pop
      push_now = '{4'h9, 4'hA, 4'hB, 4'hC};
      tick();
      wait_busy(10, cyc);
      rst_n = 1'b0;
      tick();
      check("t6_busy", int'(sts_busy), 0);
      check("t6_vld", int'(out_vld), 0);
      check("t6_last", int'(out_last), 0);
      check("t6_pop", int'(fifo_pop), 0);
      check("t6_flush", int'(sts_flush), 0);
      check("t6_bcnt", int'(sts_burst_cnt), 0);
      check("t6_fifo_left", fq.size(), 3);
      check("t6_rx_words", rx.size(), 1);
      if (rx.size() == 1) begin
         check("t6_rx_dat", int'(rx[0][DAT_W-1:0]), 9);
         check("t6_rx_last", int'(rx[0][DAT_W]), 0);
      end
      rx.delete();
      rst_n = 1'b1;

      // Randomized soak against the model
      for (int c = 0; c < 3000; c++) begin
         if (c % 40 == 0) begin
            cfg_burst_len = CNT_W'($urandom_range(0, 20));
            cfg_tmo = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 12));
         end
         cfg_en  = ($urandom_range(0, 15) != 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         rst_n   = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 2) == 0) push_now.push_back(DAT_W'($urandom));
         tick();
      end
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
